sr_pulse_ctrl: RTL

Upstream command stage for the clocked SR latch: turns two raw, asynchronous push-button inputs into clean, mutually exclusive, fixed-width `s`/`r` pulses that drive the latch's `s` and `r` pins directly. Each input is synchronized and (optionally) debounced, rising edges become requests, and a small FSM serializes them so the forbidden `s=r=1` combination can never reach the latch. A wrapping command counter is exported for observation.

---
 rtl/sr_pulse_pkg.sv | 26 ++
 rtl/sr_btn_cond.sv | 56 +++++
 rtl/sr_pulse_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/sr_pulse_pkg.sv
// Shared types and sizing helpers for the SR latch command stage.
package sr_pulse_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SET_P = 2'd1,
      RST_P = 2'd2,
      GAP   = 2'd3
   } sr_state_e;

   typedef struct packed {
      logic rst_cmd;
      logic set_cmd;
   } sr_req_t;

   localparam int CMD_CNT_W = 8;
   localparam int NUM_BTN   = 2;
   localparam int BTN_SET   = 0;
   localparam int BTN_RST   = 1;

   // Width of a counter that runs 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sr_btn_cond.sv
// One push-button lane: 2-flop synchronizer, optional debouncer, rising-edge request.
// Debounce is built only when SR_PULSE_DEBOUNCE_EN is defined.
module sr_btn_cond
   import sr_pulse_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic req
);

   if (DEB_CYCLES < 1) begin : g_bad_deb
      $error("sr_btn_cond: DEB_CYCLES must be >= 1");
   end

   logic [1:0] sync_q;
   logic       deb;
   logic       deb_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[0], btn};
   end

`ifdef SR_PULSE_DEBOUNCE_EN
   localparam int DW = cnt_w(DEB_CYCLES);
   logic [DW-1:0] deb_cnt;

   // deb only moves after DEB_CYCLES consecutive samples disagree with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb     <= 1'b0;
         deb_cnt <= '0;
      end else if (sync_q[1] == deb) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
         deb     <= sync_q[1];
         deb_cnt <= '0;
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end
`else
   assign deb = sync_q[1];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) deb_d <= 1'b0;
      else        deb_d <= deb;
   end

   assign req = deb & ~deb_d;

endmodule

// File: rtl/sr_pulse_ctrl.sv
// Serializes set/reset button requests into exclusive fixed-width s/r pulses.
// Debouncing of both buttons is enabled by SR_PULSE_DEBOUNCE_EN.
module sr_pulse_ctrl
   import sr_pulse_pkg::*;
#(
   parameter int DEB_CYCLES = 4,
   parameter int PULSE_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 set_btn,
   input  logic                 reset_btn,
   output logic                 s,
   output logic                 r,
   output logic                 busy,
   output logic [CMD_CNT_W-1:0] cmd_cnt
);

   localparam int PW = cnt_w(PULSE_W);

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_req;
   sr_req_t            req;
   sr_req_t            pend;
   sr_state_e          state;
   logic [PW-1:0]      pcnt;
   logic               want_rst;
   logic               want_set;

   assign btn_raw = {reset_btn, set_btn};

   sr_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_cond [NUM_BTN-1:0] (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_raw),
      .req   (btn_req)
   );

   assign req.set_cmd = btn_req[BTN_SET];
   assign req.rst_cmd = btn_req[BTN_RST];

   always_comb begin
      want_rst = req.rst_cmd | pend.rst_cmd;
      want_set = req.set_cmd | pend.set_cmd;
   end

   // IDLE and GAP share the dispatch decision; reset has priority and
   // discards a concurrent set so s and r can never overlap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pcnt    <= '0;
         pend    <= '0;
         s       <= 1'b0;
         r       <= 1'b0;
         busy    <= 1'b0;
         cmd_cnt <= '0;
      end else begin
         case (state)
            IDLE, GAP: begin
               s    <= 1'b0;
               r    <= 1'b0;
               pcnt <= '0;
               if (want_rst) begin
                  state   <= RST_P;
                  r       <= 1'b1;
                  busy    <= 1'b1;
                  pend    <= '0;
                  cmd_cnt <= cmd_cnt + 1'b1;
               end else if (want_set) begin
                  state        <= SET_P;
                  s            <= 1'b1;
                  busy         <= 1'b1;
                  pend.set_cmd <= 1'b0;
                  cmd_cnt      <= cmd_cnt + 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               pend.set_cmd <= pend.set_cmd | req.set_cmd;
               pend.rst_cmd <= pend.rst_cmd | req.rst_cmd;
               if (pcnt == PW'(PULSE_W - 1)) begin
                  state <= GAP;
                  s     <= 1'b0;
                  r     <= 1'b0;
               end else begin
                  pcnt <= pcnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule
